// File: rtl/gascon_perm_ctrl.sv
// Gascon permutation sequencer: runs a single-round core once per round,
// feeding each result back until the requested round count is applied.
module gascon_perm_ctrl #(
    parameter int CWIDTH     = 320,
    parameter int ROUND_W    = 16,
    parameter int MAX_ROUNDS = 12,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CWIDTH-1:0]  in_state,
    input  logic [3:0]         in_rounds,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CWIDTH-1:0]  out_state,
    output logic               err,
    output logic [CWIDTH-1:0]  core_c,
    output logic [ROUND_W-1:0] core_round,
    output logic               core_reset,
    input  logic [CWIDTH-1:0]  core_cout,
    input  logic               core_done,
    output logic               busy
);

    localparam int            WW     = $clog2(TIMEOUT) + 1;
    localparam logic [3:0]    MAXR   = 4'(MAX_ROUNDS);
    localparam logic [3:0]    LAST   = 4'(MAX_ROUNDS - 1);
    localparam logic [WW-1:0] WD_END = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} fsm_t;

    fsm_t              state;
    fsm_t              state_nx;
    logic [CWIDTH-1:0] st_q;
    logic [3:0]        idx;
    logic [3:0]        r_clamp;
    logic [WW-1:0]     wdog;
    logic              accept;
    logic              is_last;
    logic              expired;

    assign accept     = in_valid && (state == IDLE);
    assign r_clamp    = (in_rounds > MAXR) ? MAXR : in_rounds;
    assign is_last    = (idx == LAST);
    assign expired    = !core_done && (wdog == WD_END);
    assign core_c     = st_q;
    assign core_round = ROUND_W'(idx);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (r_clamp == 4'd0) ? DONE : CLEAR;
                end
            end
            CLEAR: state_nx = RUN;
            RUN: begin
                if (core_done) begin
                    state_nx = is_last ? DONE : CLEAR;
                end else if (expired) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    // The core is only released while a round is actually in flight.
    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b1;
        out_valid  = 1'b0;
        core_reset = 1'b1;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            CLEAR: ;
            RUN:   core_reset = 1'b0;
            DONE:  out_valid  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= '0;
            out_state <= '0;
            idx       <= '0;
            wdog      <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        st_q <= in_state;
                        idx  <= MAXR - r_clamp;
                        if (r_clamp == 4'd0) begin
                            out_state <= in_state;
                        end
                    end
                end
                CLEAR: wdog <= '0;
                RUN: begin
                    wdog <= wdog + WW'(1);
                    if (core_done) begin
                        st_q <= core_cout;
                        if (is_last) begin
                            out_state <= core_cout;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else if (expired) begin
                        // Abort keeps the last fully completed round.
                        err       <= 1'b1;
                        out_state <= st_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/gascon_perm_ctrl.md
Name: gascon_perm_ctrl

Overview:
Sequencer for the single-round Gascon datapath (Gascon_Core_Round). Accepts a CWIDTH-bit state and a round count over a valid/ready handshake. Iterates the round core once per round, supplying the round index, feeding each result back as the next input, and holding the core in reset between rounds. Returns the permuted state over a valid/ready handshake. It sits between the AEAD mode FSM (init/absorb/finalize) and the round core.

Parameters:
CWIDTH, 320, permutation state width in bits (multiple of 64)
ROUND_W, 16, width of core round-index port
MAX_ROUNDS, 12, full-permutation round count; legal in_rounds range 0..MAX_ROUNDS
TIMEOUT, 64, maximum cycles per round to wait for core_done before aborting

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  request: in_state/in_rounds valid
in_ready  out  1  controller idle, request can be accepted
in_state  in  CWIDTH  permutation input state
in_rounds  in  4  number of rounds to apply
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_state  out  CWIDTH  permuted state (registered)
err  out  1  qualifies out_valid: round aborted on timeout
core_c  out  CWIDTH  state to round core (= internal state register)
core_round  out  ROUND_W  round index to core, zero-extended
core_reset  out  1  active-high hold/flush of the core pipeline
core_cout  in  CWIDTH  round core result
core_done  in  1  round core result valid
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, CLEAR, RUN, DONE. Reset (async) forces IDLE and clears the state register, round index, watchdog and err. Reset-time outputs: out_valid=0, err=0, core_reset=1, in_ready=1, busy=0, out_state=0.
- in_ready = (state==IDLE), combinational. Accept occurs on a clk edge with in_valid & in_ready.
- On accept:
  - The controller loads the state register with in_state.
  - The controller clamps r = min(in_rounds, MAX_ROUNDS).
  - If r==0, the controller goes to DONE with out_state = in_state. out_valid rises the next cycle.
  - Otherwise it sets idx = MAX_ROUNDS - r and last = MAX_ROUNDS - 1, then goes to CLEAR.
- CLEAR (exactly 1 cycle): core_reset=1 and the watchdog is cleared. Next state is RUN.
- RUN: core_reset=0. core_c and core_round=idx are held stable for the whole round. The watchdog increments each cycle.
  - On an edge with core_done=1: the state register is loaded with core_cout. If idx==last, go to DONE. Otherwise idx increments and the controller goes to CLEAR.
  - If the watchdog reaches TIMEOUT-1 without core_done: set err=1 and go to DONE. out_state is the state register as of the abort, i.e. the last completed round.
- core_done is ignored in IDLE, CLEAR and DONE.
- DONE: out_valid=1, and out_state and err are held stable.
  - On out_valid & out_ready, go to IDLE and clear err. in_ready rises the next cycle.
  - With out_ready held low, the controller stays in DONE indefinitely.
- Round constant seen by the core: ((0xF - idx) << 4) | idx. Full permutation: idx 0..11, constants 0xF0, 0xE1, ... 0x4B.
- Latency from accept to out_valid is the sum over rounds of (1 + Lcore + 1) cycles. Lcore is the number of cycles from core_reset deasserting to core_done. For r==0 the latency is 1 cycle.
- core_reset stays high in IDLE, CLEAR and DONE, so the core never runs unattended.
- Reset asserted mid-RUN aborts immediately. No out_valid is produced, and the core returns to reset hold.
- A new in_valid is not accepted while busy. There is no back-to-back overlap.

Test Plan:
- Full permutation: in_state = 0, in_rounds = 12, with a core model of Lcore = 2. Required response: core_round steps 0..11 (one per CLEAR/RUN pair); out_state equals the 12-round golden reference; out_valid occurs exactly 12*(1+2+1) cycles after accept; err = 0.
- Reduced rounds: in_rounds = 6. Required response: core_round steps 6..11 (first constant 0x96, last 0x4B); exactly 6 core_reset low pulses; state matches the 6-round golden reference.
- Zero and clamp:
  - in_rounds = 0 returns out_state == in_state one cycle after accept, with the core never released from reset.
  - in_rounds = 15 behaves identically to in_rounds = 12.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid. Required response: out_valid stays 1, out_state stays stable, in_ready stays 0, in_valid is ignored. Releasing out_ready gives in_ready = 1 on the next cycle.
- Timeout: the core model never asserts core_done on round 3 of 12. Required response: out_valid with err = 1 after TIMEOUT cycles in RUN; out_state equals the 3-round result. The next transaction completes with err = 0.
- Async reset: assert reset mid-cycle during round 5. Required response: busy = 0, core_reset = 1 and in_ready = 1 before the next clk edge, with no out_valid. A following 12-round run is correct.
